// File: rtl/fft8_output_reorder.sv
// Output reorder buffer: collects butterfly result pairs into a frame and streams bins out in natural order.
// Optional FFT_REORDER_PINGPONG_EN adds a second frame bank so fill and drain can overlap.
module fft8_output_reorder #(
    parameter int unsigned SIZE_DATA = 32,
    parameter int unsigned N_POINTS  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [SIZE_DATA-1:0]        i_data_0,
    input  logic [SIZE_DATA-1:0]        i_data_1,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [SIZE_DATA-1:0]        o_data,
    output logic [$clog2(N_POINTS)-1:0] o_index,
    output logic                        o_last
);
    localparam int unsigned ADDR_W = $clog2(N_POINTS);
    localparam int unsigned PAIR_W = ADDR_W - 1;
    localparam int unsigned NPAIR  = N_POINTS / 2;
`ifdef FFT_REORDER_PINGPONG_EN
    localparam int unsigned NBANK  = 2;
`else
    localparam int unsigned NBANK  = 1;
`endif

    typedef logic [SIZE_DATA-1:0] word_t;

    word_t              mem_q [NBANK][N_POINTS];
    word_t              mem_d [NBANK][N_POINTS];
    logic [PAIR_W-1:0]  wr_q, wr_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               last_q, last_d;
    word_t              data_q, data_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic               in_fire, out_fire;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            r[i] = a[int'(ADDR_W) - 1 - i];
        end
        return r;
    endfunction

    assign in_fire  = i_valid & ready_q;
    assign out_fire = valid_q & i_ready;

`ifdef FFT_REORDER_PINGPONG_EN
    logic [1:0] full_q, full_d;
    logic       wb_q, wb_d, rb_q, rb_d;

    // Fill bank wb and drain bank rb independently; flags arbitrate ownership.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        if (in_fire) begin
            mem_d[wb_q][{wr_q, 1'b0}] = i_data_0;
            mem_d[wb_q][{wr_q, 1'b1}] = i_data_1;
            if (wr_q == PAIR_W'(NPAIR - 1)) begin
                wr_d         = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wr_d = wr_q + PAIR_W'(1);
            end
        end
        if (out_fire) begin
            if (rd_q == ADDR_W'(N_POINTS - 1)) begin
                rd_d         = '0;
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end else begin
                rd_d = rd_q + ADDR_W'(1);
            end
        end
        ready_d = ~full_d[wb_d];
        valid_d = full_d[rb_d];
        index_d = rd_d;
        last_d  = valid_d && (rd_d == ADDR_W'(N_POINTS - 1));
        data_d  = valid_d ? mem_d[rb_d][bitrev(rd_d)] : '0;
    end
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state_q, state_d;

    // Single bank: accept a whole frame, then stream it out before accepting more.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    mem_d[0][{wr_q, 1'b0}] = i_data_0;
                    mem_d[0][{wr_q, 1'b1}] = i_data_1;
                    if (wr_q == PAIR_W'(NPAIR - 1)) begin
                        wr_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        wr_d = wr_q + PAIR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rd_q == ADDR_W'(N_POINTS - 1)) begin
                        rd_d    = '0;
                        state_d = FILL;
                    end else begin
                        rd_d = rd_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
        ready_d = (state_d == FILL);
        valid_d = (state_d == DRAIN);
        index_d = rd_d;
        last_d  = valid_d && (rd_d == ADDR_W'(N_POINTS - 1));
        data_d  = valid_d ? mem_d[0][bitrev(rd_d)] : '0;
    end
`endif

    // Outputs are computed from next state so the first bin is ready with o_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < int'(NBANK); b++) begin
                for (int i = 0; i < int'(N_POINTS); i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
`ifdef FFT_REORDER_PINGPONG_EN
            full_q  <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
`else
            state_q <= FILL;
`endif
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            data_q  <= data_d;
            index_q <= index_d;
`ifdef FFT_REORDER_PINGPONG_EN
            full_q  <= full_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
`else
            state_q <= state_d;
`endif
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_data  = data_q;
    assign o_index = index_q;
    assign o_last  = last_q;

endmodule

// File: tb/tb_fft8_output_reorder.sv
// Directed bench for fft8_output_reorder: table of pair inputs and bit-reversed expected bins.
module tb_fft8_output_reorder;
    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_ready;
    logic [31:0] i_data_0, i_data_1;
    logic        o_ready, o_valid, o_last;
    logic [31:0] o_data;
    logic [2:0]  o_index;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fft8_output_reorder #(.SIZE_DATA(32), .N_POINTS(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_0(i_data_0), .i_data_1(i_data_1), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_index(o_index), .o_last(o_last)
    );

    typedef struct {
        logic [31:0] off0;
        logic [31:0] off1;
        logic [31:0] exp_off;
        logic [2:0]  exp_idx;
        logic        exp_last;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic send_pairs(input logic [31:0] base, input int cnt, input bit chk_v);
        for (int p = 0; p < cnt; p++) begin
            int t;
            i_valid  = 1'b1;
            i_data_0 = base + tbl[p].off0;
            i_data_1 = base + tbl[p].off1;
            t = 0;
            while (!o_ready && t < 50) begin
                tick();
                t++;
            end
            chk("in_ready", 32'(o_ready), 32'd1);
            tick();
            if (chk_v) chk("valid_latency", 32'(o_valid), 32'(p == 3));
        end
        i_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: one stall before each bin, 2: 20-cycle stall on bin 0
    task automatic drain(input logic [31:0] base, input int mode, input bit hold_in);
        for (int k = 0; k < 8; k++) begin
            if (mode == 2 && k == 0) begin
                i_ready = 1'b0;
                repeat (20) begin
                    tick();
                    chk("stall20_data", o_data, base + tbl[0].exp_off);
                    chk("stall20_idx", 32'(o_index), 32'd0);
                end
            end
            if (mode == 1) begin
                i_ready = 1'b0;
                tick();
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_data", o_data, base + tbl[k].exp_off);
                chk("stall_idx", 32'(o_index), 32'(tbl[k].exp_idx));
            end
            i_ready = 1'b1;
            chk("out_valid", 32'(o_valid), 32'd1);
            chk("out_data", o_data, base + tbl[k].exp_off);
            chk("out_idx", 32'(o_index), 32'(tbl[k].exp_idx));
            chk("out_last", 32'(o_last), 32'(tbl[k].exp_last));
            if (hold_in) chk("ready_in_drain", 32'(o_ready), 32'd0);
            tick();
        end
        i_ready = 1'b0;
        chk("post_valid", 32'(o_valid), 32'd0);
        chk("post_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        tbl[0] = '{32'd0, 32'd1, 32'd0, 3'd0, 1'b0};
        tbl[1] = '{32'd2, 32'd3, 32'd4, 3'd1, 1'b0};
        tbl[2] = '{32'd4, 32'd5, 32'd2, 3'd2, 1'b0};
        tbl[3] = '{32'd6, 32'd7, 32'd6, 3'd3, 1'b0};
        tbl[4] = '{32'd0, 32'd0, 32'd1, 3'd4, 1'b0};
        tbl[5] = '{32'd0, 32'd0, 32'd5, 3'd5, 1'b0};
        tbl[6] = '{32'd0, 32'd0, 32'd3, 3'd6, 1'b0};
        tbl[7] = '{32'd0, 32'd0, 32'd7, 3'd7, 1'b1};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data_0 = '0; i_data_1 = '0;
        tick();
        do_reset();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data", o_data, 32'd0);
        chk("rst_idx", 32'(o_index), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);

        // Frame 0..7 at full rate, then again with a stalling consumer
        send_pairs(32'd0, 4, 1'b1);
        drain(32'd0, 0, 1'b0);
        send_pairs(32'd0, 4, 1'b1);
        drain(32'd0, 1, 1'b0);

`ifndef FFT_REORDER_PINGPONG_EN
        // Upstream holds the next frame's first pair during drain
        send_pairs(32'h100, 4, 1'b1);
        i_valid  = 1'b1;
        i_data_0 = 32'h300 + tbl[0].off0;
        i_data_1 = 32'h300 + tbl[0].off1;
        drain(32'h100, 0, 1'b1);
        send_pairs(32'h300, 4, 1'b1);
        drain(32'h300, 0, 1'b0);
`endif

        // Partial frame discarded by reset
        send_pairs(32'h550, 2, 1'b0);
        do_reset();
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_rst_data", o_data, 32'd0);
        chk("mid_rst_idx", 32'(o_index), 32'd0);
        send_pairs(32'd8, 4, 1'b1);
        drain(32'd8, 0, 1'b0);

        // Long stall on bin 0
        send_pairs(32'h600, 4, 1'b1);
        drain(32'h600, 2, 1'b0);

`ifdef FFT_REORDER_PINGPONG_EN
        begin
            int pi, oc, cyc, fill_oc;
            logic [31:0] b;
            do_reset();
            pi = 0; oc = 0; cyc = 0; fill_oc = 99;
            i_ready = 1'b1;
            while (oc < 16 && cyc < 100) begin
                i_valid  = (pi < 8);
                b        = (pi < 4) ? 32'h200 : 32'h300;
                i_data_0 = b + tbl[pi % 4].off0;
                i_data_1 = b + tbl[pi % 4].off1;
                chk("pp_ready", 32'(o_ready), 32'((pi / 4) - (oc / 8) < 2));
                if (oc > 0) chk("pp_no_gap", 32'(o_valid), 32'd1);
                if (o_valid) begin
                    b = (oc < 8) ? 32'h200 : 32'h300;
                    chk("pp_data", o_data, b + tbl[oc % 8].exp_off);
                    chk("pp_idx", 32'(o_index), 32'(tbl[oc % 8].exp_idx));
                    chk("pp_last", 32'(o_last), 32'(tbl[oc % 8].exp_last));
                    oc++;
                end
                if (o_ready && i_valid) begin
                    pi++;
                    if (pi == 8) fill_oc = oc;
                end
                tick();
                cyc++;
            end
            i_valid = 1'b0;
            i_ready = 1'b0;
            chk("pp_count", 32'(oc), 32'd16);
            chk("pp_overlap", 32'(fill_oc < 8), 32'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
